// File: rtl/snn_timestep_scheduler_pkg.sv
// Shared definitions for the SNN timestep scheduler: default geometry and FSM states.
package snn_timestep_scheduler_pkg;

   localparam int unsigned SNN_NUM_NEURONS = 16;
   localparam int unsigned SNN_IDX_W       = 4;
   localparam int unsigned SNN_STEP_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_STEP_END = 3'd3,
      ST_FINISH   = 3'd4
   } sched_state_t;

endpackage

// File: rtl/snn_timestep_scheduler_spike_accum.sv
// Per-step spike accumulator: bit write, clear, and masked latch into the published spike vector.
module snn_spike_accum #(
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned IDX_W       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic                   wr_val,
   input  logic                   latch_en,
   input  logic [IDX_W:0]         active_cnt,
   output logic [NUM_NEURONS-1:0] spike_vec
);

   logic [NUM_NEURONS-1:0] acc;
   logic [NUM_NEURONS-1:0] mask;

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
         mask[i] = (i < 32'(active_cnt));
      end
   end

   // Latch and clear can coincide at a step end: the old contents are published first.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         spike_vec <= '0;
      end else begin
         if (latch_en) spike_vec <= acc & mask;
         if (clr) begin
            acc <= '0;
         end else if (wr_en) begin
            acc[wr_idx] <= wr_val;
         end
      end
   end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences the shared neuron core over all active neurons for each timestep of a run.
module snn_timestep_scheduler
   import snn_timestep_scheduler_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = SNN_NUM_NEURONS,
   parameter int unsigned IDX_W       = SNN_IDX_W,
   parameter int unsigned STEP_W      = SNN_STEP_W
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [IDX_W:0]         active_cnt_i,
   input  logic [STEP_W-1:0]      num_steps_i,
   output logic                   core_req_valid_o,
   input  logic                   core_req_ready_i,
   output logic [IDX_W-1:0]       core_idx_o,
   output logic [STEP_W-1:0]      core_step_o,
   input  logic                   core_rsp_valid_i,
   input  logic                   core_spike_i,
   output logic [NUM_NEURONS-1:0] spike_vec_o,
   output logic                   step_done_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic [STEP_W-1:0]      step_cnt_o
);

   localparam logic [IDX_W:0]    MAX_ACTIVE = (IDX_W+1)'(NUM_NEURONS);
   localparam logic [IDX_W:0]    ONE_ACT    = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0]  ONE_IDX    = IDX_W'(1);
   localparam logic [STEP_W-1:0] ONE_STEP   = STEP_W'(1);

   sched_state_t      state;
   logic [IDX_W:0]    active_cnt;
   logic [STEP_W-1:0] num_steps;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W:0]    active_clamped;
   logic              is_last;
   logic              acc_clr;
   logic              acc_wr;
   logic              acc_latch;

   assign core_idx_o  = idx;
   assign core_step_o = step_cnt_o;

   always_comb begin
      active_clamped = (active_cnt_i > MAX_ACTIVE) ? MAX_ACTIVE : active_cnt_i;
      is_last        = ({1'b0, idx} == (active_cnt - ONE_ACT));
      acc_clr        = !abort_i && ((state == ST_IDLE && start_i) || state == ST_STEP_END);
      acc_wr         = !abort_i && state == ST_WAIT_RSP && core_rsp_valid_i;
      acc_latch      = !abort_i && state == ST_STEP_END;
   end

   snn_spike_accum #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W)
   ) u_accum (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .clr        (acc_clr),
      .wr_en      (acc_wr),
      .wr_idx     (idx),
      .wr_val     (core_spike_i),
      .latch_en   (acc_latch),
      .active_cnt (active_cnt),
      .spike_vec  (spike_vec_o)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state            <= ST_IDLE;
         active_cnt       <= '0;
         num_steps        <= '0;
         idx              <= '0;
         core_req_valid_o <= 1'b0;
         step_done_o      <= 1'b0;
         done_o           <= 1'b0;
         busy_o           <= 1'b0;
         step_cnt_o       <= '0;
      end else begin
         step_done_o <= 1'b0;
         done_o      <= 1'b0;
         // Abort outranks start in IDLE too, so a simultaneous start is dropped.
         if (abort_i) begin
            state            <= ST_IDLE;
            core_req_valid_o <= 1'b0;
            busy_o           <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_i) begin
                     active_cnt <= active_clamped;
                     num_steps  <= num_steps_i;
                     step_cnt_o <= '0;
                     idx        <= '0;
                     busy_o     <= 1'b1;
                     if (active_clamped == '0 || num_steps_i == '0) begin
                        state <= ST_FINISH;
                     end else begin
                        state            <= ST_ISSUE;
                        core_req_valid_o <= 1'b1;
                     end
                  end
               end
               ST_ISSUE: begin
                  if (core_req_ready_i) begin
                     core_req_valid_o <= 1'b0;
                     state            <= ST_WAIT_RSP;
                  end
               end
               ST_WAIT_RSP: begin
                  if (core_rsp_valid_i) begin
                     if (is_last) begin
                        state <= ST_STEP_END;
                     end else begin
                        idx              <= idx + ONE_IDX;
                        core_req_valid_o <= 1'b1;
                        state            <= ST_ISSUE;
                     end
                  end
               end
               ST_STEP_END: begin
                  step_done_o <= 1'b1;
                  step_cnt_o  <= step_cnt_o + ONE_STEP;
                  if ((step_cnt_o + ONE_STEP) == num_steps) begin
                     state <= ST_FINISH;
                  end else begin
                     idx              <= '0;
                     core_req_valid_o <= 1'b1;
                     state            <= ST_ISSUE;
                  end
               end
               ST_FINISH: begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: begin
                  state            <= ST_IDLE;
                  core_req_valid_o <= 1'b0;
                  busy_o           <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed scoreboard bench for snn_timestep_scheduler with a behavioural neuron-core responder.
module tb_snn_timestep_scheduler;

   localparam int NN = 16;
   localparam int IW = 4;
   localparam int SW = 8;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic          start_i;
   logic          abort_i;
   logic [IW:0]   active_cnt_i;
   logic [SW-1:0] num_steps_i;
   logic          core_req_valid_o;
   logic          core_req_ready_i;
   logic [IW-1:0] core_idx_o;
   logic [SW-1:0] core_step_o;
   logic          core_rsp_valid_i;
   logic          core_spike_i;
   logic [NN-1:0] spike_vec_o;
   logic          step_done_o;
   logic          done_o;
   logic          busy_o;
   logic [SW-1:0] step_cnt_o;

   always #5 wb_clk_i = ~wb_clk_i;

   snn_timestep_scheduler #(
      .NUM_NEURONS (NN),
      .IDX_W       (IW),
      .STEP_W      (SW)
   ) dut (
      .wb_clk_i         (wb_clk_i),
      .wb_rst_i         (wb_rst_i),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .active_cnt_i     (active_cnt_i),
      .num_steps_i      (num_steps_i),
      .core_req_valid_o (core_req_valid_o),
      .core_req_ready_i (core_req_ready_i),
      .core_idx_o       (core_idx_o),
      .core_step_o      (core_step_o),
      .core_rsp_valid_i (core_rsp_valid_i),
      .core_spike_i     (core_spike_i),
      .spike_vec_o      (spike_vec_o),
      .step_done_o      (step_done_o),
      .done_o           (done_o),
      .busy_o           (busy_o),
      .step_cnt_o       (step_cnt_o)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   int            req_q[$];
   logic [15:0]   sv_q[$];
   logic [15:0]   spike_pat = '0;
   logic [15:0]   last_vec  = '0;
   int            rsp_lat   = 1;
   int            rsp_cnt   = 0;
   logic          rsp_spike = 1'b0;
   int            sd_cnt, done_cnt, hs_cnt, valid_seen, nstep;
   int            stall_left = 0;
   bit            stall_on   = 1'b0;
   logic [IW-1:0] stall_idx  = '0;
   logic [SW-1:0] stall_step = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score any handshake at this edge, then drive core-side inputs for the next edge.
   task automatic step();
      int          exp_req;
      logic [31:0] ev;
      if (core_req_valid_o && core_req_ready_i) begin
         hs_cnt++;
         if (req_q.size() > 0) exp_req = req_q.pop_front();
         else                  exp_req = -1;
         chk("req_step_idx", 32'({core_step_o, core_idx_o}), 32'(exp_req));
         rsp_cnt   = rsp_lat;
         rsp_spike = spike_pat[core_idx_o];
      end
      @(posedge wb_clk_i);
      #1;
      nstep++;
      core_rsp_valid_i = 1'b0;
      core_spike_i     = 1'b0;
      start_i          = 1'b0;
      core_req_ready_i = 1'b1;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            core_rsp_valid_i = 1'b1;
            core_spike_i     = rsp_spike;
         end
      end
      if (stall_left > 0) begin
         if (!stall_on && core_req_valid_o && core_idx_o == stall_idx) stall_on = 1'b1;
         if (stall_on) begin
            chk("stall_valid", 32'(core_req_valid_o), 32'd1);
            chk("stall_idx", 32'(core_idx_o), 32'(stall_idx));
            chk("stall_step", 32'(core_step_o), 32'(stall_step));
            core_req_ready_i = 1'b0;
            core_rsp_valid_i = 1'b1;
            core_spike_i     = 1'b1;
            start_i          = (stall_left % 2 == 1);
            stall_left--;
            if (stall_left == 0) stall_on = 1'b0;
         end
      end
      if (core_req_valid_o) valid_seen++;
      if (step_done_o) begin
         sd_cnt++;
         if (sv_q.size() > 0) ev = {16'h0, sv_q.pop_front()};
         else                 ev = '1;
         chk("spike_vec", {16'h0, spike_vec_o}, ev);
      end
      if (done_o) begin
         done_cnt++;
         chk("busy_at_done", 32'(busy_o), 32'd0);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, 32'(core_req_valid_o), 32'd0);
      chk({tag, "_idx"}, 32'(core_idx_o), 32'd0);
      chk({tag, "_step"}, 32'(core_step_o), 32'd0);
      chk({tag, "_spike_vec"}, 32'(spike_vec_o), 32'd0);
      chk({tag, "_step_done"}, 32'(step_done_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_step_cnt"}, 32'(step_cnt_o), 32'd0);
   endtask

   // Full run with ready=1 and 1-cycle response: done_o appears 2 + steps*(2*active+1) edges after start.
   task automatic run(input int act, input int steps, input logic [15:0] pat, input int extra);
      int          eff;
      int          exp_steps;
      logic [15:0] m;
      eff       = (act > NN) ? NN : act;
      exp_steps = (eff == 0 || steps == 0) ? 0 : steps;
      m         = '0;
      for (int i = 0; i < eff; i++) m[i] = 1'b1;
      for (int s = 0; s < exp_steps; s++) begin
         for (int i = 0; i < eff; i++) req_q.push_back(s * 16 + i);
         sv_q.push_back(pat & m);
      end
      spike_pat    = pat;
      sd_cnt       = 0;
      done_cnt     = 0;
      valid_seen   = 0;
      nstep        = 0;
      active_cnt_i = 5'(act);
      num_steps_i  = 8'(steps);
      start_i      = 1'b1;
      step();
      if (exp_steps > 0) chk("start_latency", 32'(core_req_valid_o), 32'd1);
      for (int c = 0; c < 3000 && done_cnt == 0; c++) step();
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("done_latency", 32'(nstep), 32'(2 + exp_steps * (2 * eff + 1) + extra));
      chk("step_done_pulses", 32'(sd_cnt), 32'(exp_steps));
      chk("step_cnt", 32'(step_cnt_o), 32'(exp_steps));
      chk("req_left", 32'(req_q.size()), 32'd0);
      chk("busy_after", 32'(busy_o), 32'd0);
      if (exp_steps == 0) chk("no_valid", 32'(valid_seen), 32'd0);
      if (exp_steps > 0) last_vec = pat & m;
      chk("final_vec", 32'(spike_vec_o), 32'(last_vec));
   endtask

   initial begin
      wb_rst_i         = 1'b1;
      start_i          = 1'b0;
      abort_i          = 1'b0;
      active_cnt_i     = '0;
      num_steps_i      = '0;
      core_req_ready_i = 1'b1;
      core_rsp_valid_i = 1'b0;
      core_spike_i     = 1'b0;
      repeat (5) step();
      check_idle_zero("reset");
      wb_rst_i = 1'b0;
      step();

      run(4, 2, 16'h000A, 0);
      run(4, 1, 16'h00F0, 0);
      run(20, 1, 16'hFFFF, 0);

      stall_idx  = 4'd2;
      stall_step = 8'd0;
      stall_left = 10;
      run(4, 1, 16'h0000, 10);

      run(0, 3, 16'hFFFF, 0);
      run(4, 0, 16'hFFFF, 0);

      // Start and abort in the same idle cycle: nothing starts.
      active_cnt_i = 5'd4;
      num_steps_i  = 8'd1;
      start_i      = 1'b1;
      abort_i      = 1'b1;
      step();
      abort_i = 1'b0;
      chk("start_abort_busy", 32'(busy_o), 32'd0);
      chk("start_abort_valid", 32'(core_req_valid_o), 32'd0);

      // Abort while waiting for the response of step 1, neuron 1.
      rsp_lat   = 3;
      spike_pat = 16'h000A;
      for (int i = 0; i < 4; i++) req_q.push_back(i);
      req_q.push_back(16);
      req_q.push_back(17);
      sv_q.push_back(16'h000A);
      sd_cnt       = 0;
      done_cnt     = 0;
      hs_cnt       = 0;
      active_cnt_i = 5'd4;
      num_steps_i  = 8'd3;
      start_i      = 1'b1;
      step();
      for (int c = 0; c < 500 && hs_cnt < 6; c++) step();
      chk("abort_reach", 32'(hs_cnt), 32'd6);
      abort_i = 1'b1;
      step();
      abort_i    = 1'b0;
      valid_seen = 0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_valid", 32'(core_req_valid_o), 32'd0);
      repeat (6) step();
      chk("abort_valid_seen", 32'(valid_seen), 32'd0);
      chk("abort_step_done", 32'(sd_cnt), 32'd1);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_step_cnt", 32'(step_cnt_o), 32'd1);
      chk("abort_vec", 32'(spike_vec_o), 32'h000A);
      chk("abort_req_left", 32'(req_q.size()), 32'd0);
      rsp_lat  = 1;
      last_vec = 16'h000A;
      run(4, 1, 16'h0005, 0);

      // Synchronous reset in the middle of a run.
      spike_pat    = 16'hFFFF;
      active_cnt_i = 5'd16;
      num_steps_i  = 8'd5;
      for (int i = 0; i < 16; i++) req_q.push_back(i);
      start_i = 1'b1;
      step();
      repeat (20) step();
      chk("midrun_busy", 32'(busy_o), 32'd1);
      wb_rst_i = 1'b1;
      step();
      check_idle_zero("midrun_reset");
      wb_rst_i = 1'b0;
      req_q.delete();
      sv_q.delete();
      rsp_cnt    = 0;
      valid_seen = 0;
      repeat (3) step();
      chk("post_reset_valid_seen", 32'(valid_seen), 32'd0);
      chk("post_reset_vec", 32'(spike_vec_o), 32'd0);
      last_vec = '0;
      run(2, 1, 16'h0003, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
